// File: rtl/opcode_sequencer_if.sv
// opcode_sequencer_if: command-in / opcode-out bus of the opcode sequencer.
//   cmd_valid/cmd_ready       command handshake
//   cmd_type..cmd_alu         command fields
//   opcode, op_issue          encoded control word and its issue strobe
//   busy, fifo_level, err     status
// slave modport is the sequencer side, master the command source side.
interface opcode_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic        cmd_src_fb;
    logic        cmd_a_sel;
    logic [1:0]  cmd_fb_sel;
    logic [1:0]  cmd_dst;
    logic [3:0]  cmd_alu;
    logic [11:0] opcode;
    logic        op_issue;
    logic        busy;
    logic [4:0]  fifo_level;
    logic        err;
    modport slave (
        input  cmd_valid, cmd_type, cmd_src_fb, cmd_a_sel, cmd_fb_sel, cmd_dst, cmd_alu,
        output cmd_ready, opcode, op_issue, busy, fifo_level, err
    );
    modport master (
        output cmd_valid, cmd_type, cmd_src_fb, cmd_a_sel, cmd_fb_sel, cmd_dst, cmd_alu,
        input  cmd_ready, opcode, op_issue, busy, fifo_level, err
    );
endinterface

// File: rtl/opcode_sequencer.sv
// opcode_sequencer: encodes commands into 12-bit opcodes, queues them, and issues
// one per GAP+1 cycles with IDLE_OP filler.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    opcode_sequencer_if.slave (command handshake, opcode output, status)
// Parameters: DEPTH (FIFO entries, power of two 2..16), GAP (idle cycles after issue, 0..7).
// Macro OPSEQ_ILLEGAL_CHECK_EN: drop ALU commands whose code collides with a load code
// (1001, 1011, 1100) and pulse err.
module opcode_sequencer #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input logic clk,
    input logic rst_n,
    opcode_sequencer_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [11:0] IDLE_OP = 12'h030;
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
    state_t        r_state;
    logic [11:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [4:0]    r_level;
    logic [2:0]    r_cnt;
    logic [11:0]   r_opcode;
    logic          r_issue;
    logic [11:0]   w_enc;
    logic          w_acc;
    logic          w_ill;
    logic          w_enq;
    logic          w_free;
    logic          w_deq;
    assign w_enc = (bus.cmd_type == 2'b11) ? {2'b00, bus.cmd_a_sel, bus.cmd_src_fb, bus.cmd_fb_sel, bus.cmd_dst, bus.cmd_alu}
                 : (bus.cmd_type == 2'b10) ? {1'b0, bus.cmd_src_fb, 2'b00, bus.cmd_fb_sel, 2'b11, 4'b1100}
                 : {bus.cmd_src_fb, 3'b000, bus.cmd_fb_sel, 2'b11, bus.cmd_type[0] ? 4'b1011 : 4'b1001};
    assign bus.cmd_ready  = r_level != 5'(DEPTH);
    assign bus.busy       = (r_level != 5'd0) || (r_state != IDLE);
    assign bus.fifo_level = r_level;
    assign bus.opcode     = r_opcode;
    assign bus.op_issue   = r_issue;
    assign w_acc = bus.cmd_valid && bus.cmd_ready;
`ifdef OPSEQ_ILLEGAL_CHECK_EN
    logic r_err;
    assign w_ill   = (bus.cmd_type == 2'b11) && (bus.cmd_alu inside {4'b1001, 4'b1011, 4'b1100});
    assign bus.err = r_err;
`else
    assign w_ill   = 1'b0;
    assign bus.err = 1'b0;
`endif
    assign w_enq = w_acc && !w_ill;
    // The sequencer may take a new head in IDLE, on the last cycle of HOLD,
    // or straight out of ISSUE when no gap is configured.
    assign w_free = (r_state == IDLE) || (r_state == ISSUE && GAP == 0) || (r_state == HOLD && r_cnt == 3'd0);
    assign w_deq  = w_free && (r_level != 5'd0);
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wptr] <= w_enc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= 5'd0;
            r_cnt    <= 3'd0;
            r_opcode <= IDLE_OP;
            r_issue  <= 1'b0;
`ifdef OPSEQ_ILLEGAL_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
`ifdef OPSEQ_ILLEGAL_CHECK_EN
            r_err    <= w_acc && w_ill;
`endif
            r_level  <= r_level + 5'(w_enq) - 5'(w_deq);
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) begin
                r_rptr   <= r_rptr + 1'b1;
                r_opcode <= r_mem[r_rptr];
                r_issue  <= 1'b1;
                r_state  <= ISSUE;
            end else begin
                r_opcode <= IDLE_OP;
                r_issue  <= 1'b0;
                if (r_state == ISSUE && GAP > 0) begin
                    r_state <= HOLD;
                    r_cnt   <= 3'(GAP - 1);
                end else if (r_state == HOLD && r_cnt != 3'd0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_opcode_sequencer.sv
// tb_opcode_sequencer: randomized self-checking bench against a queue-based reference model.
module tb_opcode_sequencer;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    opcode_sequencer_if bus ();
    opcode_sequencer #(.DEPTH(DEPTH), .GAP(GAP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] q[$];
    int          rem = 0;
    logic [11:0] exp_op;
    logic        exp_iss;
    logic        exp_err;
    logic [20:0] act;
    logic [20:0] exp;
    localparam logic [20:0] RST_VAL = {12'h030, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0};

    function automatic logic [11:0] enc(logic [1:0] t, logic s, logic a, logic [1:0] f, logic [1:0] d, logic [3:0] alu);
        case (t)
            2'd0:    return {s, 1'b0, 1'b0, 1'b0, f, 2'b11, 4'b1001};
            2'd1:    return {s, 1'b0, 1'b0, 1'b0, f, 2'b11, 4'b1011};
            2'd2:    return {1'b0, s, 1'b0, 1'b0, f, 2'b11, 4'b1100};
            default: return {1'b0, 1'b0, a, s, f, d, alu};
        endcase
    endfunction

    function automatic logic illegal(logic [1:0] t, logic [3:0] alu);
`ifdef OPSEQ_ILLEGAL_CHECK_EN
        return t == 2'd3 && (alu == 4'd9 || alu == 4'd11 || alu == 4'd12);
`else
        return 1'b0;
`endif
    endfunction

    task automatic rnd_cmd(input logic v, input logic legal);
        bus.cmd_valid  = v;
        bus.cmd_type   = 2'($urandom);
        bus.cmd_src_fb = 1'($urandom);
        bus.cmd_a_sel  = 1'($urandom);
        bus.cmd_fb_sel = 2'($urandom);
        bus.cmd_dst    = 2'($urandom);
        bus.cmd_alu    = 4'($urandom);
        if (legal && bus.cmd_alu inside {4'd9, 4'd11, 4'd12}) bus.cmd_alu = 4'd0;
    endtask

    // Model: the queue holds encoded words; rem counts the cycles the sequencer stays
    // occupied after an issue (the issue cycle plus GAP filler cycles). A new head may be
    // taken once at most one occupied cycle remains.
    task automatic tick();
        int          s   = q.size();
        bit          deq = (s > 0) && (rem <= 1);
        bit          acc = bus.cmd_valid && (s != DEPTH);
        bit          ill = illegal(bus.cmd_type, bus.cmd_alu);
        logic [11:0] w   = enc(bus.cmd_type, bus.cmd_src_fb, bus.cmd_a_sel, bus.cmd_fb_sel, bus.cmd_dst, bus.cmd_alu);
        @(posedge clk);
        if (deq) begin
            exp_op  = q.pop_front();
            exp_iss = 1'b1;
            rem     = GAP + 1;
        end else begin
            exp_op  = 12'h030;
            exp_iss = 1'b0;
            if (rem > 0) rem--;
        end
        if (acc && !ill) q.push_back(w);
        exp_err = acc && ill;
        #1;
        act = {bus.opcode, bus.op_issue, bus.cmd_ready, bus.busy, bus.fifo_level, bus.err};
        exp = {exp_op, exp_iss, q.size() != DEPTH, (q.size() != 0) || (rem != 0), 5'(q.size()), exp_err};
    endtask

    task automatic test_reset();
        rnd_cmd(1'b0, 1'b1);
        rst_n = 1'b0;
        #12;
        act = {bus.opcode, bus.op_issue, bus.cmd_ready, bus.busy, bus.fifo_level, bus.err};
        n_cmp++;
        if (act !== RST_VAL) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", act, RST_VAL);
        end
        q.delete();
        rem = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [11:0] want [3] = '{12'h039, 12'h47C, 12'h393};
        for (int i = 0; i < 3; i++) begin
            rnd_cmd(1'b1, 1'b1);
            case (i)
                0: begin bus.cmd_type = 2'd0; bus.cmd_src_fb = 1'b0; bus.cmd_fb_sel = 2'd0; end
                1: begin bus.cmd_type = 2'd2; bus.cmd_src_fb = 1'b1; bus.cmd_fb_sel = 2'd1; end
                default: begin
                    bus.cmd_type = 2'd3; bus.cmd_a_sel = 1'b1; bus.cmd_src_fb = 1'b1;
                    bus.cmd_fb_sel = 2'd2; bus.cmd_dst = 2'd1; bus.cmd_alu = 4'd3;
                end
            endcase
            tick();
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL directed_accept[%0d]: got %h want %h", i, act, exp); end
            bus.cmd_valid = 1'b0;
            tick();
            n_cmp++;
            if (bus.opcode !== want[i] || bus.op_issue !== 1'b1) begin
                n_bad++;
                $display("FAIL directed_opcode[%0d]: got %h/%b want %h/1", i, bus.opcode, bus.op_issue, want[i]);
            end
            for (int k = 0; k < GAP + 2; k++) begin
                tick();
                n_cmp++;
                if (act !== exp) begin n_bad++; $display("FAIL directed_after[%0d]: got %h want %h", i, act, exp); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int  accepted = 0;
        int  issues   = 0;
        int  last     = -1;
        bit  saw_full = 0;
        for (int c = 0; c < 30; c++) begin
            rnd_cmd(c < 8, 1'b1);
            if (c < 8 && q.size() != DEPTH) accepted++;
            tick();
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL b2b_cycle[%0d]: got %h want %h", c, act, exp); end
            if (bus.fifo_level == 5'd4 && !bus.cmd_ready) saw_full = 1;
            if (bus.op_issue) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last !== GAP + 1) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", c - last, GAP + 1); end
                end
                last = c;
                issues++;
            end
        end
        n_cmp++;
        if (!saw_full) begin n_bad++; $display("FAIL b2b_full: got 0 want 1"); end
        n_cmp++;
        if (issues !== accepted) begin n_bad++; $display("FAIL b2b_issue_count: got %0d want %0d", issues, accepted); end
    endtask

    task automatic test_illegal();
        rnd_cmd(1'b1, 1'b1);
        bus.cmd_type = 2'd3;
        bus.cmd_alu  = 4'b1001;
        tick();
        n_cmp++;
`ifdef OPSEQ_ILLEGAL_CHECK_EN
        if (bus.err !== 1'b1 || bus.fifo_level !== 5'd0) begin
            n_bad++; $display("FAIL illegal_err: got err=%b lvl=%0d want err=1 lvl=0", bus.err, bus.fifo_level);
        end
`else
        if (bus.err !== 1'b0 || bus.fifo_level !== 5'd1) begin
            n_bad++; $display("FAIL illegal_err: got err=%b lvl=%0d want err=0 lvl=1", bus.err, bus.fifo_level);
        end
`endif
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL illegal_after[%0d]: got %h want %h", k, act, exp); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rnd_cmd(1'($urandom_range(0, 2) != 0), 1'b0);
            tick();
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL random[%0d]: got %h want %h", c, act, exp); end
        end
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL random_drain[%0d]: got %h want %h", c, act, exp); end
        end
    endtask

    task automatic test_reset_mid_hold();
        bit found  = 0;
        int issues = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            rnd_cmd(1'b1, 1'b1);
            tick();
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL hold_fill[%0d]: got %h want %h", c, act, exp); end
            found = (q.size() >= 3) && (rem == 1) && !exp_iss;
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL hold_reach: got 0 want 1"); end
        bus.cmd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        act = {bus.opcode, bus.op_issue, bus.cmd_ready, bus.busy, bus.fifo_level, bus.err};
        n_cmp++;
        if (act !== RST_VAL) begin n_bad++; $display("FAIL hold_reset: got %h want %h", act, RST_VAL); end
        q.delete();
        rem = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.op_issue) issues++;
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL hold_release[%0d]: got %h want %h", c, act, exp); end
        end
        n_cmp++;
        if (issues !== 0) begin n_bad++; $display("FAIL hold_no_reissue: got %0d want 0", issues); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_illegal();
        test_random();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
